// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and requester count for the ALU arbiter slice.
package alu_pkg;

  localparam int NREQ = 2;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_SL12  = 4'b1011;
  localparam logic [3:0] ALU_AUIPC = 4'b1100;
  localparam logic [3:0] ALU_NOP   = 4'b1111;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-ALU arbiter.
interface alu_rr_arbiter_if #(parameter int N = 32);

  logic [alu_pkg::NREQ-1:0]         req_valid_i;
  logic [alu_pkg::NREQ-1:0]         req_ready_o;
  logic [alu_pkg::NREQ-1:0][3:0]    req_ctrl_i;
  logic [alu_pkg::NREQ-1:0][N-1:0]  req_a_i;
  logic [alu_pkg::NREQ-1:0][N-1:0]  req_b_i;
  logic [alu_pkg::NREQ-1:0]         req_cin_i;
  logic [alu_pkg::NREQ-1:0]         rsp_valid_o;
  logic [alu_pkg::NREQ-1:0]         rsp_ready_i;
  logic [alu_pkg::NREQ-1:0][N-1:0]  rsp_res_o;
  logic [alu_pkg::NREQ-1:0]         rsp_cout_o;
  logic [alu_pkg::NREQ-1:0]         rsp_cmp_o;

  modport slave (
    input  req_valid_i, req_ctrl_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_cout_o, rsp_cmp_o
  );

  modport master (
    output req_valid_i, req_ctrl_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_cout_o, rsp_cmp_o
  );

endinterface

// File: rtl/alu.sv
// Combinational N-bit ALU; undefined opcodes yield all-zero results.
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  input  logic [3:0]   i_ctrl,
  output logic [N-1:0] o_res,
  output logic         o_cout,
  output logic         o_cmp
);

  localparam int SHW = $clog2(N);

  logic [N:0]     w_sum;
  logic [SHW-1:0] w_sh;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  assign w_sh  = i_b[SHW-1:0];

  // Opcode decode
  always_comb begin
    o_res  = '0;
    o_cout = 1'b0;
    o_cmp  = 1'b0;
    case (i_ctrl)
      ALU_ADD:   begin o_res = w_sum[N-1:0]; o_cout = w_sum[N]; end
      ALU_SUB:   o_res = i_a - i_b;
      ALU_OR:    o_res = i_a | i_b;
      ALU_XOR:   o_res = i_a ^ i_b;
      ALU_AND:   o_res = i_a & i_b;
      ALU_SRL:   o_res = i_a >> w_sh;
      ALU_SRA:   o_res = N'($signed(i_a) >>> w_sh);
      ALU_SLL:   o_res = i_a << w_sh;
      ALU_SLTU:  o_cmp = (i_a < i_b);
      ALU_SLT:   o_cmp = ($signed(i_a) < $signed(i_b));
      ALU_SL12:  o_res = {i_b[N-13:0], 12'h000};
      ALU_AUIPC: o_res = i_a + {i_b[N-13:0], 12'h000};
      default:   o_res = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester other than i_last wins.
module rr_arb2 (
  input  logic [1:0] i_elig,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // One-hot grant selection
  always_comb begin
    o_gnt = 2'b00;
    case (i_elig)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and one
// registered response slot per requester (fixed one-cycle latency).
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_rr_arbiter_if.slave   bus
);

  logic [NREQ-1:0]         w_elig;
  logic [NREQ-1:0]         w_gnt;
  logic                    r_last;
  logic [N-1:0]            w_alu_a;
  logic [N-1:0]            w_alu_b;
  logic                    w_alu_cin;
  logic [3:0]              w_alu_ctrl;
  logic [N-1:0]            w_alu_res;
  logic                    w_alu_cout;
  logic                    w_alu_cmp;
  logic [NREQ-1:0]         r_rsp_valid;
  logic [NREQ-1:0][N-1:0]  r_rsp_res;
  logic [NREQ-1:0]         r_rsp_cout;
  logic [NREQ-1:0]         r_rsp_cmp;

  // A slot being drained this cycle can accept a new result on the same edge
  assign w_elig = bus.req_valid_i & (~r_rsp_valid | bus.rsp_ready_i);

  rr_arb2 u_arb (
    .i_elig (w_elig),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign bus.req_ready_o = w_gnt;

  // ALU operand mux; idle cycles present requester 0 operands with a no-op
  always_comb begin
    w_alu_a    = bus.req_a_i[0];
    w_alu_b    = bus.req_b_i[0];
    w_alu_cin  = bus.req_cin_i[0];
    w_alu_ctrl = ALU_NOP;
    if (w_gnt[1]) begin
      w_alu_a    = bus.req_a_i[1];
      w_alu_b    = bus.req_b_i[1];
      w_alu_cin  = bus.req_cin_i[1];
      w_alu_ctrl = bus.req_ctrl_i[1];
    end else if (w_gnt[0]) begin
      w_alu_ctrl = bus.req_ctrl_i[0];
    end else begin
      w_alu_ctrl = ALU_NOP;
    end
  end

  alu #(.N(N)) u_alu (
    .i_a    (w_alu_a),
    .i_b    (w_alu_b),
    .i_cin  (w_alu_cin),
    .i_ctrl (w_alu_ctrl),
    .o_res  (w_alu_res),
    .o_cout (w_alu_cout),
    .o_cmp  (w_alu_cmp)
  );

  // Round-robin pointer, moves only on an actual grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1];
    end else begin
      r_last <= r_last;
    end
  end

  // Response slots: load on grant, else clear valid when consumed, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_res   <= '0;
      r_rsp_cout  <= '0;
      r_rsp_cmp   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_res[i]   <= w_alu_res;
          r_rsp_cout[i]  <= w_alu_cout;
          r_rsp_cmp[i]   <= w_alu_cmp;
        end else if (bus.rsp_ready_i[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end else begin
          r_rsp_valid[i] <= r_rsp_valid[i];
        end
      end
    end
  end

  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_res_o   = r_rsp_res;
  assign bus.rsp_cout_o  = r_rsp_cout;
  assign bus.rsp_cmp_o   = r_rsp_cmp;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and randomized checks of alu_rr_arbiter against a behavioural model.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.N(N)) bus ();

  alu_rr_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [1:0]   s_valid;
  logic [1:0]   s_rr;
  logic [3:0]   s_ctrl [2];
  logic [N-1:0] s_a    [2];
  logic [N-1:0] s_b    [2];
  logic         s_cin  [2];
  logic [1:0]   seen_ready;

  bit           m_valid [2];
  logic [N-1:0] m_res   [2];
  bit           m_cout  [2];
  bit           m_cmp   [2];
  int           m_last;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the opcode table; returns {cout, cmp, res}
  function automatic logic [N+1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic cin);
    logic [63:0] sum;
    int sh;
    sh = int'(b % N);
    case (op)
      ALU_ADD: begin
        sum = 64'(a) + 64'(b) + 64'(cin);
        return {sum[N], 1'b0, sum[N-1:0]};
      end
      ALU_SUB:   return {2'b00, N'(a - b)};
      ALU_OR:    return {2'b00, a | b};
      ALU_XOR:   return {2'b00, a ^ b};
      ALU_AND:   return {2'b00, a & b};
      ALU_SRL:   return {2'b00, N'(a / (64'd1 << sh))};
      ALU_SRA:   return {2'b00, N'($signed(a) >>> sh)};
      ALU_SLL:   return {2'b00, N'(64'(a) * (64'd1 << sh))};
      ALU_SLTU:  return {1'b0, (a < b), {N{1'b0}}};
      ALU_SLT:   return {1'b0, ($signed(a) < $signed(b)), {N{1'b0}}};
      ALU_SL12:  return {2'b00, N'(64'(b) * 64'd4096)};
      ALU_AUIPC: return {2'b00, N'(64'(a) + 64'(b) * 64'd4096)};
      default:   return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = '0;
      m_cout[i]  = 1'b0;
      m_cmp[i]   = 1'b0;
    end
    m_last = 1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin);
    s_ctrl[i] = op;
    s_a[i]    = a;
    s_b[i]    = b;
    s_cin[i]  = cin;
  endtask

  // Drive one cycle from negedge, check outputs, advance model at posedge
  task automatic step();
    int g;
    bit e0, e1;
    logic [1:0] exp_rdy;
    logic [N+1:0] r;
    bus.req_valid_i = s_valid;
    bus.rsp_ready_i = s_rr;
    for (int i = 0; i < 2; i++) begin
      bus.req_ctrl_i[i] = s_ctrl[i];
      bus.req_a_i[i]    = s_a[i];
      bus.req_b_i[i]    = s_b[i];
      bus.req_cin_i[i]  = s_cin[i];
    end
    #1;
    e0 = s_valid[0] && (!m_valid[0] || s_rr[0]);
    e1 = s_valid[1] && (!m_valid[1] || s_rr[1]);
    g = -1;
    if (e0 && e1) g = 1 - m_last;
    else if (e0) g = 0;
    else if (e1) g = 1;
    exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
    seen_ready = bus.req_ready_o;
    check_eq("req_ready", bus.req_ready_o, exp_rdy);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rsp_valid%0d", i), bus.rsp_valid_o[i], m_valid[i]);
      if (m_valid[i]) begin
        check_eq($sformatf("rsp_res%0d", i), bus.rsp_res_o[i], m_res[i]);
        check_eq($sformatf("rsp_cout%0d", i), bus.rsp_cout_o[i], m_cout[i]);
        check_eq($sformatf("rsp_cmp%0d", i), bus.rsp_cmp_o[i], m_cmp[i]);
      end
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          r = ref_alu(s_ctrl[i], s_a[i], s_b[i], s_cin[i]);
          m_valid[i] = 1'b1;
          m_res[i]   = r[N-1:0];
          m_cmp[i]   = r[N];
          m_cout[i]  = r[N+1];
        end else if (s_rr[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (g >= 0) m_last = g;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 2'b00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1;
    s_valid = 2'b00;
    s_rr = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, ALU_NOP, '0, '0, 1'b0);
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bus.req_ctrl_i[i] = ALU_NOP;
      bus.req_a_i[i]    = '0;
      bus.req_b_i[i]    = '0;
      bus.req_cin_i[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_eq("reset_valid", bus.rsp_valid_o, 2'b00);
    check_eq("reset_res0", bus.rsp_res_o[0], 32'h0);
    check_eq("reset_res1", bus.rsp_res_o[1], 32'h0);
    check_eq("reset_cout", bus.rsp_cout_o, 2'b00);
    check_eq("reset_cmp", bus.rsp_cmp_o, 2'b00);
    rst = 1'b0;

    // single request, ADD with carry-in
    s_rr = 2'b11;
    set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b1);
    s_valid = 2'b01;
    step();
    check_eq("add_ready0", seen_ready, 2'b01);
    check_eq("add_valid", bus.rsp_valid_o, 2'b01);
    check_eq("add_res", bus.rsp_res_o[0], 32'd13);
    check_eq("add_cout", bus.rsp_cout_o[0], 1'b0);

    // contention alternates starting with requester 0
    do_reset();
    set_req(0, ALU_SUB, 32'd10, 32'd3, 1'b0);
    set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd0, 1'b0);
    s_valid = 2'b11;
    s_rr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("alt_grant%0d", k), seen_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 2) check_eq("alt_res0", bus.rsp_res_o[0], 32'd7);
      if (k == 3) begin
        check_eq("alt_cmp1", bus.rsp_cmp_o[1], 1'b1);
        check_eq("alt_res1", bus.rsp_res_o[1], 32'd0);
      end
    end

    // backpressure on requester 1
    do_reset();
    s_rr = 2'b00;
    set_req(1, ALU_XOR, 32'hF0, 32'hFF, 1'b0);
    s_valid = 2'b10;
    step();
    check_eq("bp_res", bus.rsp_res_o[1], 32'h0F);
    set_req(1, ALU_ADD, 32'd1, 32'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("bp_blocked", seen_ready[1], 1'b0);
      check_eq("bp_hold", bus.rsp_res_o[1], 32'h0F);
    end
    s_rr = 2'b10;
    step();
    check_eq("bp_accept", seen_ready[1], 1'b1);
    check_eq("bp_new_res", bus.rsp_res_o[1], 32'd3);

    // overflow and arithmetic shift
    s_rr = 2'b11;
    s_valid = 2'b01;
    set_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check_eq("ovf_res", bus.rsp_res_o[0], 32'd0);
    check_eq("ovf_cout", bus.rsp_cout_o[0], 1'b1);
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4, 1'b0);
    step();
    check_eq("sra_res", bus.rsp_res_o[0], 32'hF800_0000);

    // reset with an unconsumed result pending
    s_rr = 2'b01;
    set_req(0, ALU_AND, 32'hF0F0, 32'hFF00, 1'b0);
    step();
    s_rr = 2'b00;
    do_reset();
    check_eq("rst_mid_valid", bus.rsp_valid_o[0], 1'b0);
    set_req(1, ALU_OR, 32'd1, 32'd2, 1'b0);
    s_valid = 2'b11;
    s_rr = 2'b11;
    step();
    check_eq("rst_mid_prio", seen_ready, 2'b01);

    // undefined opcode passes through and returns zeros
    s_valid = 2'b10;
    set_req(1, 4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    step();
    check_eq("ill_valid", bus.rsp_valid_o[1], 1'b1);
    check_eq("ill_res", bus.rsp_res_o[1], 32'd0);
    check_eq("ill_cout", bus.rsp_cout_o[1], 1'b0);
    check_eq("ill_cmp", bus.rsp_cmp_o[1], 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      s_valid = 2'($urandom);
      s_rr[0] = ($urandom_range(0, 3) != 0);
      s_rr[1] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == ALU_SL12 || op == ALU_AUIPC) op = ALU_ADD;
        set_req(i, op, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                1'($urandom));
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
      rst = 1'b0;
    end

    s_valid = 2'b00;
    step();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU instance between two requesters (e.g. the integer pipe and the address-generation / CSR path), N-bit datapath.
- Round-robin arbitration with valid/ready handshakes on the request and response sides.
- One registered response slot per requester. Results return to the requester that issued the op.
- Sits between the issue logic and the ALU; it is the only driver of the ALU's A/B/Cin/Ctrl inputs.

Parameters:
- N, 32, datapath width of A, B and Res; passed to the ALU.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  2  per requester: operation offered
- req_ready_o  out  2  per requester: operation accepted this cycle
- req_ctrl_i  in  2x4  per requester: ALU opcode (alu_pkg encoding)
- req_a_i  in  2xN  per requester: operand A
- req_b_i  in  2xN  per requester: operand B
- req_cin_i  in  2  per requester: carry-in (used by ADD only)
- rsp_valid_o  out  2  per requester: response slot holds a result
- rsp_ready_i  in  2  per requester: requester consumes the result
- rsp_res_o  out  2xN  per requester: registered Res
- rsp_cout_o  out  2  per requester: registered Cout
- rsp_cmp_o  out  2  per requester: registered Cmp

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid_o=0, rsp_res_o=0, rsp_cout_o=0, rsp_cmp_o=0.
  - Round-robin pointer last_grant=1, so requester 0 has priority on the first contention.
  - In-flight results are discarded, including any result the requester had not yet taken.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and its slot can take a result: rsp_valid_o[i]=0 or rsp_ready_i[i]=1 in the same cycle.
- Grant:
  - At most one grant per cycle.
  - One eligible requester: it is granted.
  - Both eligible: the requester not equal to last_grant is granted.
  - last_grant updates only on an actual grant.
- req_ready_o[i] is combinational, =1 only for the granted requester and 0 otherwise.
- req_ready_o must not depend on the other requester's req_*_i operand values.
- Datapath muxing:
  - ALU inputs come from the granted requester.
  - When there is no grant, ALU inputs are forced to requester 0's inputs with Ctrl=4'b1111 (no-op, result unused).
- Latency: a request accepted at edge k produces rsp_valid_o[i]=1 with its result from edge k onward. Fixed 1 cycle.
- Response slot i, at each edge:
  - If granted this cycle: load Res/Cout/Cmp and set valid.
  - Otherwise, if rsp_ready_i[i]=1: clear valid.
  - Otherwise: hold.
- A simultaneous drain and new grant on the same slot loads the new result (full throughput, 1 op/cycle/requester when uncontended).
- Response data holds stable while rsp_valid_o=1 and rsp_ready_i=0.
- Opcodes 1010 and 1101–1111 are passed through to the ALU unchanged and return Res=0, Cout=0, Cmp=0; the arbiter performs no opcode checking.
- Cout is meaningful for ADD only; Cmp for SLT/SLTU only; Res=0 for SLT/SLTU.
- A requester may drop req_valid_i before it is accepted; no ordering obligation applies to unaccepted requests.
- Fairness bound: under continuous contention, each requester is granted at least every 2nd cycle, provided its slot is drained.

Decomposition:
- alu_pkg:
  - 4-bit opcode localparams ALU_ADD=0000, ALU_SUB=0001, ALU_OR=0010, ALU_XOR=0011, ALU_AND=0100, ALU_SRL=0101, ALU_SRA=0110, ALU_SLL=0111, ALU_SLTU=1000, ALU_SLT=1001, ALU_LUI=1010, ALU_SL12=1011, ALU_AUIPC=1100, ALU_NOP=1111.
  - Requester count constant NREQ=2.
- Sub-module rr_arb2 (pure grant logic):
  - Inputs: eligibility vector, last_grant.
  - Outputs: one-hot grant.
- The existing ALU is instantiated directly. The response slots stay in the top.

Test Plan:
- Reset, then req0 only: ctrl=ADD, A=5, B=7, cin=1, rsp_ready=1 -> ready0=1 in that cycle; next cycle rsp_valid0=1, res=13, cout=0; rsp_valid1 stays 0.
- Contention: both valid every cycle, both rsp_ready=1; req0 SUB A=10 B=3, req1 SLT A=-1 B=0 -> grants alternate 0,1,0,1; rsp0 res=7; rsp1 cmp=1, res=0.
- Backpressure: req1 XOR A=0xF0 B=0xFF with rsp_ready1=0 -> rsp1 res=0x0F held stable; second req1 not granted (ready1=0) until rsp_ready1=1, then accepted in that same cycle.
- Overflow: ADD A=0xFFFFFFFF, B=1, cin=0 -> res=0, cout=1. SRA A=0x80000000, B=4 -> res=0xF8000000.
- Reset mid-operation: grant req0 AND, assert rst next cycle with rsp_ready0=0 -> rsp_valid0=0 after the reset edge; next contention grants req0 first.
- Illegal opcode 1101 from req1 -> accepted normally; res=0, cout=0, cmp=0 after 1 cycle.
